// File: rtl/sparsity_dvfs_sequencer.sv
// ---------------------------------------------------------------------------
// sparsity_dvfs_sequencer
//
// Purpose:
//   Turns sparsity mode changes into DVFS override codes for the power
//   manager. Each mode is looked up in a small code table and the resulting
//   target is applied one rail at a time, in an order that is safe for the
//   logic:
//     raising  -> voltage first, then frequency
//     lowering -> frequency first, then voltage
//   After each rail step the sequencer waits a programmable settle time.
//
// Optional feature (macro SPARSITY_DVFS_THROTTLE_EN):
//   When defined, a target evaluated while power_mw > power_budget is derated
//   by one code (floored at 0), and throttle_active reports this. When
//   undefined, there is no derate, throttle_active is tied low and the power
//   inputs are ignored.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   enable                       sequencer enable; low aborts to IDLE
//   mode_valid, mode_in          1-cycle new-mode strobe and the mode
//   mode_code_lut                target code per mode, mode m at [m*CODE_W +: CODE_W]
//   volt/freq_settle_cycles      settle wait after a voltage / frequency step
//   power_mw, power_budget       current power and budget (throttle only)
//   volt_ov_en, freq_ov_en       override enables (registered copy of enable)
//   volt_ov, freq_ov             override codes
//   cur_code                     last fully applied code
//   busy                         high whenever the FSM is not IDLE
//   done_pulse                   1 cycle when a transition completes
//   transition_count             completed transitions, saturating
//   throttle_active              last evaluated target was derated
// ---------------------------------------------------------------------------
module sparsity_dvfs_sequencer #(
    parameter int CODE_W       = 3,
    parameter int MAX_CODE     = 7,
    parameter int DEFAULT_CODE = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  mode_valid,
    input  logic [1:0]            mode_in,
    input  logic [4*CODE_W-1:0]   mode_code_lut,
    input  logic [7:0]            volt_settle_cycles,
    input  logic [7:0]            freq_settle_cycles,
    input  logic [15:0]           power_mw,
    input  logic [15:0]           power_budget,
    output logic                  volt_ov_en,
    output logic                  freq_ov_en,
    output logic [CODE_W-1:0]     volt_ov,
    output logic [CODE_W-1:0]     freq_ov,
    output logic [CODE_W-1:0]     cur_code,
    output logic                  busy,
    output logic                  done_pulse,
    output logic [15:0]           transition_count,
    output logic                  throttle_active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STEP1   = 3'd1,
        SETTLE1 = 3'd2,
        STEP2   = 3'd3,
        SETTLE2 = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [CODE_W-1:0] MAX_C = CODE_W'(MAX_CODE);
    localparam logic [CODE_W-1:0] DEF_C = CODE_W'(DEFAULT_CODE);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CODE_W-1:0]   tgt_q, tgt_d;         // target of the active sequence
    logic                up_q, up_d;           // 1: raising, voltage rail first
    logic [7:0]          ctr_q, ctr_d;         // settle countdown
    logic [CODE_W-1:0]   volt_q, volt_d;
    logic [CODE_W-1:0]   freq_q, freq_d;
    logic [CODE_W-1:0]   cur_q, cur_d;
    logic                pend_vld_q, pend_vld_d;
    logic [1:0]          pend_mode_q, pend_mode_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                thr_q, thr_d;
    logic                en_q;

    // -----------------------------------------------------------------------
    // Code table, clamped to the highest legal code
    // -----------------------------------------------------------------------
    logic [3:0][CODE_W-1:0] lut_clamped;

    for (genvar m = 0; m < 4; m++) begin : g_lut
        logic [CODE_W-1:0] raw;
        assign raw            = mode_code_lut[m*CODE_W +: CODE_W];
        assign lut_clamped[m] = (raw > MAX_C) ? MAX_C : raw;
    end

    // -----------------------------------------------------------------------
    // Evaluation target. A live strobe always beats the pending slot; in IDLE
    // the pending slot is never valid, so the same mux serves both states.
    // -----------------------------------------------------------------------
    logic [1:0]        eval_mode;
    logic [CODE_W-1:0] eval_raw;
    logic [CODE_W-1:0] eval_tgt;
    logic              eval_thr;

    assign eval_mode = mode_valid ? mode_in : pend_mode_q;
    assign eval_raw  = lut_clamped[eval_mode];

`ifdef SPARSITY_DVFS_THROTTLE_EN
    logic over_budget;
    assign over_budget = (power_mw > power_budget);
    assign eval_thr    = over_budget;
    assign eval_tgt    = (over_budget && (eval_raw != '0)) ? (eval_raw - CODE_W'(1)) : eval_raw;
    assign throttle_active = thr_q;
`else
    logic unused_throttle;
    assign unused_throttle = ^{power_mw, power_budget, thr_q};
    assign eval_thr        = 1'b0;
    assign eval_tgt        = eval_raw;
    assign throttle_active = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next state / datapath
    // -----------------------------------------------------------------------
    logic do_eval;

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        up_d        = up_q;
        ctr_d       = ctr_q;
        volt_d      = volt_q;
        freq_d      = freq_q;
        cur_d       = cur_q;
        pend_vld_d  = pend_vld_q;
        pend_mode_d = pend_mode_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        thr_d       = thr_q;
        do_eval     = 1'b0;

        if (!enable) begin
            // Abort: rails and cur_code keep whatever was last written.
            state_d    = IDLE;
            pend_vld_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mode_valid) do_eval = 1'b1;
                end
                STEP1: begin
                    if (up_q) begin
                        volt_d = tgt_q;
                        ctr_d  = volt_settle_cycles;
                    end else begin
                        freq_d = tgt_q;
                        ctr_d  = freq_settle_cycles;
                    end
                    state_d = SETTLE1;
                end
                SETTLE1: begin
                    if (ctr_q == 8'd0) state_d = STEP2;
                    else               ctr_d   = ctr_q - 8'd1;
                end
                STEP2: begin
                    if (up_q) begin
                        freq_d = tgt_q;
                        ctr_d  = freq_settle_cycles;
                    end else begin
                        volt_d = tgt_q;
                        ctr_d  = volt_settle_cycles;
                    end
                    state_d = SETTLE2;
                end
                SETTLE2: begin
                    if (ctr_q == 8'd0) begin
                        // Commit on entry to DONE so DONE compares the next
                        // request against the code just applied.
                        state_d = DONE;
                        done_d  = 1'b1;
                        cur_d   = tgt_q;
                        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    end else begin
                        ctr_d = ctr_q - 8'd1;
                    end
                end
                DONE: begin
                    if (mode_valid || pend_vld_q) do_eval = 1'b1;
                    else                          state_d = IDLE;
                    // Whatever was pending is either consumed now or
                    // superseded by the newer live strobe.
                    pend_vld_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase

            // Requests arriving mid-sequence park in the 1-deep slot; the
            // newest one overwrites any older one.
            if (mode_valid && (state_q inside {STEP1, SETTLE1, STEP2, SETTLE2})) begin
                pend_vld_d  = 1'b1;
                pend_mode_d = mode_in;
            end

            if (do_eval) begin
                thr_d = eval_thr;
                tgt_d = eval_tgt;
                if (eval_tgt == cur_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = STEP1;
                    up_d    = (eval_tgt > cur_q);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tgt_q       <= DEF_C;
            up_q        <= 1'b0;
            ctr_q       <= 8'd0;
            volt_q      <= DEF_C;
            freq_q      <= DEF_C;
            cur_q       <= DEF_C;
            pend_vld_q  <= 1'b0;
            pend_mode_q <= 2'd0;
            cnt_q       <= 16'd0;
            done_q      <= 1'b0;
            thr_q       <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            up_q        <= up_d;
            ctr_q       <= ctr_d;
            volt_q      <= volt_d;
            freq_q      <= freq_d;
            cur_q       <= cur_d;
            pend_vld_q  <= pend_vld_d;
            pend_mode_q <= pend_mode_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            thr_q       <= thr_d;
            en_q        <= enable;
        end
    end

    assign volt_ov_en       = en_q;
    assign freq_ov_en       = en_q;
    assign volt_ov          = volt_q;
    assign freq_ov          = freq_q;
    assign cur_code         = cur_q;
    assign busy             = (state_q != IDLE);
    assign done_pulse       = done_q;
    assign transition_count = cnt_q;

endmodule

// File: tb/tb_sparsity_dvfs_sequencer.sv
module tb_sparsity_dvfs_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        mode_valid;
    logic [1:0]  mode_in;
    logic [11:0] mode_code_lut;
    logic [7:0]  volt_settle_cycles;
    logic [7:0]  freq_settle_cycles;
    logic [15:0] power_mw;
    logic [15:0] power_budget;
    logic        volt_ov_en, freq_ov_en;
    logic [2:0]  volt_ov, freq_ov, cur_code;
    logic        busy, done_pulse, throttle_active;
    logic [15:0] transition_count;

    always #5 clk = ~clk;

    sparsity_dvfs_sequencer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .enable             (enable),
        .mode_valid         (mode_valid),
        .mode_in            (mode_in),
        .mode_code_lut      (mode_code_lut),
        .volt_settle_cycles (volt_settle_cycles),
        .freq_settle_cycles (freq_settle_cycles),
        .power_mw           (power_mw),
        .power_budget       (power_budget),
        .volt_ov_en         (volt_ov_en),
        .freq_ov_en         (freq_ov_en),
        .volt_ov            (volt_ov),
        .freq_ov            (freq_ov),
        .cur_code           (cur_code),
        .busy               (busy),
        .done_pulse         (done_pulse),
        .transition_count   (transition_count),
        .throttle_active    (throttle_active)
    );

    typedef struct {
        logic [2:0]  code;
        logic [15:0] cnt;
        logic        thr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every completed transition must match the oldest
    // expected result.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && done_pulse === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got done_pulse with cur_code %0d, expected none", cur_code);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_cur_code", 32'(cur_code), 32'(mon_e.code));
                chk("sb_count", 32'(transition_count), 32'(mon_e.cnt));
                chk("sb_throttle", 32'(throttle_active), 32'(mon_e.thr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_mode(input logic [1:0] m);
        mode_valid = 1'b1;
        mode_in    = m;
        tick();
        mode_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    int   exp_code6;
    logic exp_thr6;

    initial begin
        reset_n            = 1'b0;
        enable             = 1'b1;
        mode_valid         = 1'b0;
        mode_in            = 2'd0;
        mode_code_lut      = {3'd1, 3'd2, 3'd4, 3'd6};   // m3..m0
        volt_settle_cycles = 8'd2;
        freq_settle_cycles = 8'd3;
        power_mw           = 16'd0;
        power_budget       = 16'd6000;

        // T1 reset / enable
        tickn(2);
        chk("rst_volt_ov", 32'(volt_ov), 32'd3);
        chk("rst_freq_ov", 32'(freq_ov), 32'd3);
        chk("rst_cur_code", 32'(cur_code), 32'd3);
        chk("rst_ov_en", 32'({volt_ov_en, freq_ov_en}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(transition_count), 32'd0);
        chk("rst_done", 32'(done_pulse), 32'd0);
        reset_n = 1'b1;
        chk("ov_en_before_edge", 32'(volt_ov_en), 32'd0);
        tick();
        chk("ov_en_after_edge", 32'({volt_ov_en, freq_ov_en}), 32'd3);

        // T2 raise 3 -> 6, vs=2 fs=3
        sb_q.push_back('{code: 3'd6, cnt: 16'd1, thr: 1'b0});
        pulse_mode(2'd0);                       // E0
        chk("t2_busy", 32'(busy), 32'd1);
        tick();                                 // E1
        chk("t2_volt_e1", 32'(volt_ov), 32'd6);
        chk("t2_freq_e1", 32'(freq_ov), 32'd3);
        tickn(3);                               // E4
        chk("t2_freq_e4", 32'(freq_ov), 32'd3);
        tick();                                 // E5
        chk("t2_freq_e5", 32'(freq_ov), 32'd6);
        tickn(3);                               // E8
        chk("t2_done_e8", 32'(done_pulse), 32'd0);
        tick();                                 // E9
        chk("t2_done_e9", 32'(done_pulse), 32'd1);
        chk("t2_count", 32'(transition_count), 32'd1);
        tick();
        chk("t2_idle", 32'(busy), 32'd0);
        tick();

        // T3 lower 6 -> 1, vs=fs=0
        volt_settle_cycles = 8'd0;
        freq_settle_cycles = 8'd0;
        sb_q.push_back('{code: 3'd1, cnt: 16'd2, thr: 1'b0});
        pulse_mode(2'd3);                       // E0
        tick();                                 // E1
        chk("t3_freq_e1", 32'(freq_ov), 32'd1);
        chk("t3_volt_e1", 32'(volt_ov), 32'd6);
        tickn(2);                               // E3
        chk("t3_volt_e3", 32'(volt_ov), 32'd1);
        chk("t3_done_e3", 32'(done_pulse), 32'd0);
        tick();                                 // E4
        chk("t3_done_e4", 32'(done_pulse), 32'd1);
        tick();
        chk("t3_idle", 32'(busy), 32'd0);

        // T4 collision: 1 -> 4, then mode 3 and mode 2 while busy (last wins)
        volt_settle_cycles = 8'd1;
        freq_settle_cycles = 8'd1;
        sb_q.push_back('{code: 3'd4, cnt: 16'd3, thr: 1'b0});
        sb_q.push_back('{code: 3'd2, cnt: 16'd4, thr: 1'b0});
        pulse_mode(2'd1);                       // E0
        tick();                                 // E1
        chk("t4_volt_e1", 32'(volt_ov), 32'd4);
        mode_valid = 1'b1;
        mode_in    = 2'd3;
        tick();                                 // E2
        mode_in    = 2'd2;
        tick();                                 // E3
        mode_valid = 1'b0;
        tick();                                 // E4
        chk("t4_no_retarget_freq", 32'(freq_ov), 32'd4);
        chk("t4_no_retarget_volt", 32'(volt_ov), 32'd4);
        wait_idle(40);
        chk("t4_volt_final", 32'(volt_ov), 32'd2);
        chk("t4_freq_final", 32'(freq_ov), 32'd2);
        chk("t4_count", 32'(transition_count), 32'd4);

        // T5 no-op: mode 2 maps to 2 == cur_code
        pulse_mode(2'd2);
        chk("t5_noop_busy", 32'(busy), 32'd0);
        tick();
        chk("t5_noop_done", 32'(done_pulse), 32'd0);
        chk("t5_noop_count", 32'(transition_count), 32'd4);

        // T5 abort mid-SETTLE1
        volt_settle_cycles = 8'd5;
        pulse_mode(2'd0);                       // E0, target 6 (up)
        tick();                                 // E1
        chk("t5_abort_volt_e1", 32'(volt_ov), 32'd6);
        tick();                                 // E2, in SETTLE1
        enable = 1'b0;
        tick();                                 // E3
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_cur", 32'(cur_code), 32'd2);
        chk("t5_abort_volt_hold", 32'(volt_ov), 32'd6);
        chk("t5_abort_freq_hold", 32'(freq_ov), 32'd2);
        chk("t5_abort_ov_en", 32'(volt_ov_en), 32'd0);
        pulse_mode(2'd3);                       // ignored while disabled
        chk("t5_disabled_ignore", 32'(busy), 32'd0);
        enable = 1'b1;
        tick();

        // T5 reset mid-sequence
        volt_settle_cycles = 8'd3;
        freq_settle_cycles = 8'd3;
        pulse_mode(2'd3);                       // E0, target 1 (down)
        tick();                                 // E1
        chk("t5_rst_freq_e1", 32'(freq_ov), 32'd1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_volt", 32'(volt_ov), 32'd3);
        chk("t5_rst_freq", 32'(freq_ov), 32'd3);
        chk("t5_rst_cur", 32'(cur_code), 32'd3);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_count", 32'(transition_count), 32'd0);
        chk("t5_rst_ov_en", 32'(freq_ov_en), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // T6 throttle: 7000 mW over a 6000 mW budget, mode 0 (lut 6)
`ifdef SPARSITY_DVFS_THROTTLE_EN
        exp_code6 = 5;
        exp_thr6  = 1'b1;
`else
        exp_code6 = 6;
        exp_thr6  = 1'b0;
`endif
        volt_settle_cycles = 8'd0;
        freq_settle_cycles = 8'd0;
        power_mw = 16'd7000;
        sb_q.push_back('{code: 3'(exp_code6), cnt: 16'd1, thr: exp_thr6});
        pulse_mode(2'd0);
        chk("t6_throttle_flag", 32'(throttle_active), 32'(exp_thr6));
        wait_idle(20);
        chk("t6_cur_code", 32'(cur_code), 32'(exp_code6));
        chk("t6_volt", 32'(volt_ov), 32'(exp_code6));
        power_mw = 16'd0;
        tickn(2);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
